// File: rtl/icetap_pkg.sv
// ---------------------------------------------------------------------------
// icetap_pkg
//
// Shared definitions for the icetap SPI-to-scan-chain bridge.
//   state_e            : bridge transaction FSM states
//   CHAIN_CMD ..       : well-known chain addresses used by the icetap core
// ---------------------------------------------------------------------------
package icetap_pkg;

    // Transaction phases: waiting for select, shifting in the chain
    // address, then streaming payload bits through the selected chain.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        PAYLOAD = 2'd2
    } state_e;

    // Chain map of the icetap logic analyser.
    localparam int CHAIN_CMD          = 0;
    localparam int CHAIN_STATUS       = 1;
    localparam int CHAIN_DATA         = 2;
    localparam int CHAIN_STORE_MASK   = 3;
    localparam int CHAIN_TRIGGER_MASK = 4;

endpackage : icetap_pkg

// File: rtl/icetap_sync_edge.sv
// ---------------------------------------------------------------------------
// icetap_sync_edge
//
// Multi-stage synchroniser for one asynchronous input, plus edge detection
// against a one-cycle delayed copy of the synchronised level.
//
// Ports:
//   clk_i    : sampling clock
//   rst_ni   : asynchronous active-low reset (flops load RESET_VAL)
//   async_i  : asynchronous input
//   sync_o   : synchronised level
//   rise_o   : high for one cycle when sync_o goes 0 -> 1
//   fall_o   : high for one cycle when sync_o goes 1 -> 0
// ---------------------------------------------------------------------------
module icetap_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;

    assign sync_d = {sync_q[STAGES-2:0], async_i};

    // Resetting to the idle level of the line keeps reset release from
    // looking like an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule : icetap_sync_edge

// File: rtl/icetap_spi_bridge.sv
// ---------------------------------------------------------------------------
// icetap_spi_bridge
//
// SPI slave that oversamples the SPI bus in the scan_clk domain, decodes an
// ADDR_W-bit chain address (MSB first) and then drives the addressed scan
// chain with capture / shift / update strobes. Supports all four SPI modes
// through CPOL/CPHA.
//
// Ports:
//   scan_clk          : sole clock, >= 4x spi_clk
//   scan_reset_       : asynchronous active-low reset
//   spi_clk/ss_/mosi  : asynchronous SPI inputs
//   spi_miso          : registered SPI data out
//   chain_capture     : one-cycle pulse, load parallel data into chain
//   chain_shift_ena   : one-cycle pulse per payload sample edge
//   chain_shift_data  : synchronised MOSI bit accompanying chain_shift_ena
//   chain_update      : one-cycle pulse at the end of a payload transaction
//   chain_shift_out   : serial output of each chain, source for MISO
//   bad_addr          : sticky, last decoded address was out of range
//   xfer_len          : payload bit count of the last completed transaction
// ---------------------------------------------------------------------------
module icetap_spi_bridge
    import icetap_pkg::*;
#(
    parameter int NUM_CHAINS  = 5,
    parameter int ADDR_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                  scan_clk,
    input  logic                  scan_reset_,
    input  logic                  spi_clk,
    input  logic                  spi_ss_,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [NUM_CHAINS-1:0] chain_capture,
    output logic [NUM_CHAINS-1:0] chain_shift_ena,
    output logic                  chain_shift_data,
    output logic [NUM_CHAINS-1:0] chain_update,
    input  logic [NUM_CHAINS-1:0] chain_shift_out,
    output logic                  bad_addr,
    output logic [CNT_W-1:0]      xfer_len
);

    localparam int                BCNT_W   = $clog2(ADDR_W + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(ADDR_W - 1);

    // Synchronised SPI signals and their edges.
    logic clk_level_unused, clk_rise, clk_fall;
    logic ss_level_unused, ss_rise, ss_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    // Edge classification derived from CPOL/CPHA.
    logic lead_edge, trail_edge, sample_edge, launch_edge;

    // Address decode.
    logic [ADDR_W-1:0]     addr_shift;
    logic [NUM_CHAINS-1:0] sel_cur;
    logic [NUM_CHAINS-1:0] sel_new;
    logic                  addr_valid;
    logic                  miso_bit;

    // FSM and registered outputs.
    state_e                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [BCNT_W-1:0]     bit_cnt_q;
    logic [CNT_W-1:0]      pay_cnt_q;
    logic [NUM_CHAINS-1:0] capture_q;
    logic [NUM_CHAINS-1:0] shift_ena_q;
    logic                  shift_data_q;
    logic [NUM_CHAINS-1:0] update_q;
    logic                  miso_q;
    logic                  bad_addr_q;
    logic [CNT_W-1:0]      xfer_len_q;

    // spi_clk idles at CPOL, so its synchroniser resets there.
    icetap_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (CPOL != 0)
    ) u_sync_clk (
        .clk_i   (scan_clk),
        .rst_ni  (scan_reset_),
        .async_i (spi_clk),
        .sync_o  (clk_level_unused),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall)
    );

    icetap_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_ss (
        .clk_i   (scan_clk),
        .rst_ni  (scan_reset_),
        .async_i (spi_ss_),
        .sync_o  (ss_level_unused),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    // MOSI goes through the same depth as spi_clk so that the bit seen at
    // a detected clock edge is the one the master set up for that edge.
    icetap_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_mosi (
        .clk_i   (scan_clk),
        .rst_ni  (scan_reset_),
        .async_i (spi_mosi),
        .sync_o  (mosi_sync),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    // The leading edge moves the clock away from its idle level; the
    // sample edge is the leading one in CPHA=0 modes and the trailing one
    // otherwise, and data is launched on whichever edge is left.
    always_comb begin
        if (CPOL == 0) begin
            lead_edge  = clk_rise;
            trail_edge = clk_fall;
        end else begin
            lead_edge  = clk_fall;
            trail_edge = clk_rise;
        end
        if (CPHA == 0) begin
            sample_edge = lead_edge;
            launch_edge = trail_edge;
        end else begin
            sample_edge = trail_edge;
            launch_edge = lead_edge;
        end
    end

    // One-hot chain selects for the current address and for the address
    // as it will be once the current MOSI bit is shifted in. An
    // out-of-range address decodes to all zeros, which doubles as the
    // validity flag.
    always_comb begin
        addr_shift = ADDR_W'({addr_q, mosi_sync});
        sel_cur    = '0;
        sel_new    = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                sel_cur[i] = 1'b1;
            end
            if (addr_shift == ADDR_W'(i)) begin
                sel_new[i] = 1'b1;
            end
        end
    end

    assign addr_valid = |sel_cur;
    assign miso_bit   = |(sel_cur & chain_shift_out);

    // Transaction FSM. All strobes default to zero each cycle so that they
    // are single-cycle pulses. A select release takes priority over any
    // clock edge detected in the same cycle.
    always_ff @(posedge scan_clk or negedge scan_reset_) begin
        if (!scan_reset_) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            bit_cnt_q    <= '0;
            pay_cnt_q    <= '0;
            capture_q    <= '0;
            shift_ena_q  <= '0;
            shift_data_q <= 1'b0;
            update_q     <= '0;
            miso_q       <= 1'b0;
            bad_addr_q   <= 1'b0;
            xfer_len_q   <= '0;
        end else begin
            capture_q    <= '0;
            shift_ena_q  <= '0;
            shift_data_q <= 1'b0;
            update_q     <= '0;

            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_q    <= ADDR;
                        addr_q     <= '0;
                        bit_cnt_q  <= '0;
                        pay_cnt_q  <= '0;
                        bad_addr_q <= 1'b0;
                    end
                end

                ADDR: begin
                    if (ss_rise) begin
                        state_q <= IDLE;
                        miso_q  <= 1'b0;
                    end else if (sample_edge) begin
                        addr_q    <= addr_shift;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= PAYLOAD;
                            if (|sel_new) begin
                                capture_q <= sel_new;
                            end else begin
                                bad_addr_q <= 1'b1;
                            end
                        end
                    end
                end

                PAYLOAD: begin
                    if (ss_rise) begin
                        state_q    <= IDLE;
                        miso_q     <= 1'b0;
                        xfer_len_q <= pay_cnt_q;
                        if (addr_valid && (pay_cnt_q != '0)) begin
                            update_q <= sel_cur;
                        end
                    end else begin
                        // Bits are counted even for a bad address so that
                        // xfer_len reflects what the master actually sent.
                        if (sample_edge) begin
                            if (addr_valid) begin
                                shift_ena_q  <= sel_cur;
                                shift_data_q <= mosi_sync;
                            end
                            if (pay_cnt_q != {CNT_W{1'b1}}) begin
                                pay_cnt_q <= pay_cnt_q + 1'b1;
                            end
                        end
                        if (launch_edge) begin
                            miso_q <= addr_valid ? miso_bit : 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign spi_miso         = miso_q;
    assign chain_capture    = capture_q;
    assign chain_shift_ena  = shift_ena_q;
    assign chain_shift_data = shift_data_q;
    assign chain_update     = update_q;
    assign bad_addr         = bad_addr_q;
    assign xfer_len         = xfer_len_q;

endmodule : icetap_spi_bridge

// File: tb/tb_icetap_spi_bridge.sv
// ---------------------------------------------------------------------------
// tb_icetap_spi_bridge
//
// Three bridge instances share scan_clk and scan_reset_:
//   dutA : mode 0, default widths
//   dutB : mode 3, chain 2 backed by a 16-bit model chain preloaded 0xBEEF
//   dutC : mode 0, 3-bit payload counter to reach saturation
// Each has its own SPI bus, driven by a bit-banged master task. Expected
// strobes are queued when a transaction is issued and checked by a monitor.
// ---------------------------------------------------------------------------
module tb_icetap_spi_bridge;
    import icetap_pkg::*;

    localparam int HALF     = 60;
    localparam int KIND_CAP = 0;
    localparam int KIND_SH  = 1;
    localparam int KIND_UPD = 2;

    typedef struct {
        int   dut;
        int   kind;
        int   idx;
        logic data;
    } event_t;

    event_t expQ[$];
    int     nChecks = 0;
    int     nFails  = 0;

    logic        scanClk = 1'b0;
    logic        scanReset_ = 1'b0;
    logic [2:0]  spiClk;
    logic [2:0]  spiSs;
    logic [2:0]  spiMosi;
    logic        misoA, misoB, misoC;
    logic [4:0]  capA, shA, updA, capB, shB, updB, capC, shC, updC;
    logic        sdA, sdB, sdC, badA, badB, badC;
    logic [15:0] xferA, xferB;
    logic [2:0]  xferC;
    logic [15:0] chainB;
    logic [4:0]  shOutB;
    logic [31:0] rb;

    icetap_spi_bridge #(.CPOL(0), .CPHA(0)) dutA (
        .scan_clk(scanClk), .scan_reset_(scanReset_),
        .spi_clk(spiClk[0]), .spi_ss_(spiSs[0]), .spi_mosi(spiMosi[0]),
        .spi_miso(misoA), .chain_capture(capA), .chain_shift_ena(shA),
        .chain_shift_data(sdA), .chain_update(updA),
        .chain_shift_out(5'b11111), .bad_addr(badA), .xfer_len(xferA)
    );

    icetap_spi_bridge #(.CPOL(1), .CPHA(1)) dutB (
        .scan_clk(scanClk), .scan_reset_(scanReset_),
        .spi_clk(spiClk[1]), .spi_ss_(spiSs[1]), .spi_mosi(spiMosi[1]),
        .spi_miso(misoB), .chain_capture(capB), .chain_shift_ena(shB),
        .chain_shift_data(sdB), .chain_update(updB),
        .chain_shift_out(shOutB), .bad_addr(badB), .xfer_len(xferB)
    );

    icetap_spi_bridge #(.CPOL(0), .CPHA(0), .CNT_W(3)) dutC (
        .scan_clk(scanClk), .scan_reset_(scanReset_),
        .spi_clk(spiClk[2]), .spi_ss_(spiSs[2]), .spi_mosi(spiMosi[2]),
        .spi_miso(misoC), .chain_capture(capC), .chain_shift_ena(shC),
        .chain_shift_data(sdC), .chain_update(updC),
        .chain_shift_out(5'b00000), .bad_addr(badC), .xfer_len(xferC)
    );

    // Free-running scan clock, 10 time units per period.
    always #5 scanClk = ~scanClk;

    // Model of chain 2 behind dutB: parallel load on capture, shift left
    // with the MOSI bit on each shift strobe, MSB is the serial output.
    always @(posedge scanClk or negedge scanReset_) begin
        if (!scanReset_) begin
            chainB <= 16'h0000;
        end else if (capB[CHAIN_DATA]) begin
            chainB <= 16'hBEEF;
        end else if (shB[CHAIN_DATA]) begin
            chainB <= {chainB[14:0], sdB};
        end
    end

    assign shOutB = {2'b00, chainB[15], 2'b00};

    // Single named comparison, counted in the summary.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Compare one observed strobe against the head of the expectation queue.
    task automatic compareEvent(input int dut, input int kind,
                                input logic [4:0] vec, input logic data);
        event_t e;
        logic [4:0] expVec;
        nChecks++;
        if (expQ.size() == 0) begin
            nFails++;
            $display("[TB] FAIL unexpected strobe: dut%0d kind %0d vec %b, expected none",
                     dut, kind, vec);
        end else begin
            e = expQ.pop_front();
            expVec = 5'b00001 << e.idx;
            if (e.dut != dut || e.kind != kind || vec !== expVec ||
                (kind == KIND_SH && data !== e.data)) begin
                nFails++;
                $display("[TB] FAIL strobe: got dut%0d kind %0d vec %b data %b, expected dut%0d kind %0d vec %b data %b",
                         dut, kind, vec, data, e.dut, e.kind, expVec, e.data);
            end
        end
    endtask

    task automatic observe(input int dut, input logic [4:0] cap, input logic [4:0] sh,
                           input logic sd, input logic [4:0] upd);
        if (cap != 5'b0) compareEvent(dut, KIND_CAP, cap, 1'b0);
        if (sh != 5'b0)  compareEvent(dut, KIND_SH, sh, sd);
        if (upd != 5'b0) compareEvent(dut, KIND_UPD, upd, 1'b0);
    endtask

    // Monitor: strobes are registered on the rising edge, so each one is
    // seen exactly once on the falling edge.
    always @(negedge scanClk) begin
        observe(0, capA, shA, sdA, updA);
        observe(1, capB, shB, sdB, updB);
        observe(2, capC, shC, sdC, updC);
    end

    function automatic logic misoOf(input int which);
        case (which)
            0:       return misoA;
            1:       return misoB;
            default: return misoC;
        endcase
    endfunction

    // Bit-banged SPI master. Sends addrBits address bits (8 = full address)
    // then the payload MSB first, and queues the strobes the bridge should
    // produce. With resetAfter >= 0, scan reset is asserted after that many
    // payload bits and left asserted on return.
    task automatic applyStimulus(input int which, input int addr, input int nPay,
                                 input logic [31:0] payload, input int addrBits,
                                 input int resetAfter, output logic [31:0] readBack);
        logic       cpol, cpha, b;
        logic [7:0] a8;
        int         payBits;
        event_t     e;
        cpol     = (which == 1);
        cpha     = (which == 1);
        a8       = addr[7:0];
        readBack = 32'h0;
        payBits  = (addrBits < 8) ? 0 : ((resetAfter >= 0) ? resetAfter : nPay);
        if (addrBits == 8 && addr < 5) begin
            e.dut  = which;
            e.idx  = addr;
            e.kind = KIND_CAP;
            e.data = 1'b0;
            expQ.push_back(e);
            for (int i = 0; i < payBits; i++) begin
                e.kind = KIND_SH;
                e.data = payload[nPay-1-i];
                expQ.push_back(e);
            end
            if (resetAfter < 0 && nPay > 0) begin
                e.kind = KIND_UPD;
                e.data = 1'b0;
                expQ.push_back(e);
            end
        end
        spiSs[which] = 1'b0;
        #HALF;
        for (int i = 0; i < addrBits + payBits; i++) begin
            b = (i < 8) ? a8[7-i] : payload[nPay-1-(i-8)];
            if (!cpha) begin
                spiMosi[which] = b;
                #HALF;
                if (i >= 8) readBack = {readBack[30:0], misoOf(which)};
                spiClk[which] = ~cpol;
                #HALF;
                spiClk[which] = cpol;
            end else begin
                spiClk[which]  = ~cpol;
                spiMosi[which] = b;
                #HALF;
                if (i >= 8) readBack = {readBack[30:0], misoOf(which)};
                spiClk[which] = cpol;
                #HALF;
            end
        end
        #HALF;
        if (resetAfter >= 0) begin
            @(negedge scanClk);
            scanReset_ = 1'b0;
            #2;
            spiSs[which] = 1'b1;
        end else begin
            spiSs[which] = 1'b1;
            repeat (12) @(negedge scanClk);
        end
        spiMosi[which] = 1'b0;
    endtask

    // Bounded wait for the monitor to consume all queued strobes.
    task automatic waitDrain(input string name);
        for (int c = 0; c < 300 && expQ.size() != 0; c++) @(negedge scanClk);
        checkOutput(name, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    // Directed test sequence.
    initial begin
        spiClk  = 3'b010;
        spiSs   = 3'b111;
        spiMosi = 3'b000;
        repeat (5) @(negedge scanClk);
        checkOutput("reset capture A", 32'(capA), 32'h0);
        checkOutput("reset xfer_len A", 32'(xferA), 32'h0);
        checkOutput("reset bad_addr A", 32'(badA), 32'h0);
        checkOutput("reset miso A", 32'(misoA), 32'h0);
        checkOutput("reset miso B", 32'(misoB), 32'h0);
        scanReset_ = 1'b1;
        repeat (5) @(negedge scanClk);

        $display("[TB] mode 0, CMD chain, payload 0xA5");
        applyStimulus(0, CHAIN_CMD, 8, 32'hA5, 8, -1, rb);
        waitDrain("t1 strobes");
        checkOutput("t1 miso read", rb, 32'hFF);
        checkOutput("t1 xfer_len", 32'(xferA), 32'd8);
        checkOutput("t1 bad_addr", 32'(badA), 32'h0);

        $display("[TB] zero-payload transaction to STORE_MASK");
        applyStimulus(0, CHAIN_STORE_MASK, 0, 32'h0, 8, -1, rb);
        waitDrain("t2 strobes");
        checkOutput("t2 xfer_len", 32'(xferA), 32'd0);
        checkOutput("t2 miso idle", 32'(misoA), 32'h0);

        $display("[TB] out-of-range address 0x07");
        applyStimulus(0, 7, 8, 32'h5A, 8, -1, rb);
        waitDrain("t3 strobes");
        checkOutput("t3 bad_addr", 32'(badA), 32'h1);
        checkOutput("t3 miso read", rb, 32'h0);
        checkOutput("t3 xfer_len", 32'(xferA), 32'd8);

        $display("[TB] valid TRIGGER_MASK transaction, 5 payload bits");
        applyStimulus(0, CHAIN_TRIGGER_MASK, 5, 32'h13, 8, -1, rb);
        waitDrain("t4 strobes");
        checkOutput("t4 bad_addr cleared", 32'(badA), 32'h0);
        checkOutput("t4 xfer_len", 32'(xferA), 32'd5);

        $display("[TB] select released after 5 address bits");
        applyStimulus(0, CHAIN_STATUS, 0, 32'h0, 5, -1, rb);
        waitDrain("t5 strobes");
        checkOutput("t5 xfer_len kept", 32'(xferA), 32'd5);
        checkOutput("t5 miso", 32'(misoA), 32'h0);

        $display("[TB] mode 3, DATA chain, 16 payload bits");
        applyStimulus(1, CHAIN_DATA, 16, 32'h1234, 8, -1, rb);
        waitDrain("t6 strobes");
        checkOutput("t6 miso read", rb, 32'hBEEF);
        checkOutput("t6 xfer_len", 32'(xferB), 32'd16);
        checkOutput("t6 bad_addr", 32'(badB), 32'h0);

        $display("[TB] payload counter saturation");
        applyStimulus(2, CHAIN_CMD, 10, 32'h2D5, 8, -1, rb);
        waitDrain("t7 strobes");
        checkOutput("t7 xfer_len saturated", 32'(xferC), 32'd7);
        checkOutput("t7 bad_addr", 32'(badC), 32'h0);

        $display("[TB] reset after 3 payload bits");
        applyStimulus(0, CHAIN_STATUS, 8, 32'hC3, 8, 3, rb);
        checkOutput("t8 capture in reset", 32'(capA), 32'h0);
        checkOutput("t8 shift in reset", 32'(shA), 32'h0);
        checkOutput("t8 shift data in reset", 32'(sdA), 32'h0);
        checkOutput("t8 update in reset", 32'(updA), 32'h0);
        checkOutput("t8 miso in reset", 32'(misoA), 32'h0);
        checkOutput("t8 xfer_len in reset", 32'(xferA), 32'h0);
        repeat (20) @(negedge scanClk);
        scanReset_ = 1'b1;
        repeat (10) @(negedge scanClk);
        waitDrain("t8 strobes");

        $display("[TB] full transaction after reset");
        applyStimulus(0, CHAIN_STATUS, 8, 32'h3C, 8, -1, rb);
        waitDrain("t9 strobes");
        checkOutput("t9 miso read", rb, 32'hFF);
        checkOutput("t9 xfer_len", 32'(xferA), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule : tb_icetap_spi_bridge

// File: doc/icetap_spi_bridge.md
Name: icetap_spi_bridge

Overview:
- Parametrised SPI-slave-to-scan-chain bridge. Replaces the fixed five-register SPI front end of the icetap logic analyser.
- Oversamples an external SPI bus in the scan_clk domain, decodes an ADDR_W-bit chain address, and drives NUM_CHAINS generic scan chains with per-chain capture/shift/update strobes.
- Adds support for all four SPI modes, a synchronised MOSI path, bad-address reporting and transfer-length reporting.

Parameters:
- NUM_CHAINS, 5, number of scan chains addressed (1..2^ADDR_W).
- ADDR_W, 8, address phase length in bits, MSB first.
- CPOL, 0, SPI clock idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- SYNC_STAGES, 2, synchroniser depth for spi_clk/spi_ss_/spi_mosi (>=2).
- CNT_W, 16, width of payload bit counter.

Ports:
- scan_clk  in  1  sole clock; oversamples SPI at >=4x spi_clk.
- scan_reset_  in  1  asynchronous active-low reset.
- spi_clk  in  1  SPI clock, asynchronous.
- spi_ss_  in  1  SPI select, active low, asynchronous.
- spi_mosi  in  1  SPI data in, asynchronous.
- spi_miso  out  1  SPI data out, registered.
- chain_capture  out  NUM_CHAINS  one-cycle pulse: load parallel data into the addressed chain.
- chain_shift_ena  out  NUM_CHAINS  one-cycle pulse per payload sample edge.
- chain_shift_data  out  1  synchronised MOSI bit accompanying chain_shift_ena.
- chain_update  out  NUM_CHAINS  one-cycle pulse at end of a transaction with payload.
- chain_shift_out  in  NUM_CHAINS  serial output of each chain, source for MISO.
- bad_addr  out  1  sticky: last decoded address >= NUM_CHAINS.
- xfer_len  out  CNT_W  payload bit count of the last completed transaction.

Behaviour:
- Reset: every output is 0, FSM is IDLE, all counters are 0, and synchroniser flops reset to their idle level (spi_clk=CPOL, spi_ss_=1, spi_mosi=0).
- spi_mosi is delayed through the same SYNC_STAGES as spi_clk, so data and clock stay aligned.
- Edge detection: compare synchroniser output with a 1-cycle delayed copy. The leading edge is the transition away from CPOL.
  - Sample edge = leading if CPHA=0, else trailing.
  - Launch edge = the opposite edge.
- All strobes and spi_miso are registered. Each asserts exactly 1 scan_clk cycle after the event is visible at synchroniser output.
- FSM:
  - IDLE: on the synced ss_ falling edge, go to ADDR. Clear the address shift register, bit counter and payload counter; clear bad_addr.
  - ADDR: on each sample edge, addr <= {addr, mosi} and cnt++. On the ADDR_W-th sample edge, go to PAYLOAD.
    - If addr < NUM_CHAINS: pulse chain_capture[addr].
    - Else: set bad_addr; no strobes for this transaction.
  - PAYLOAD: on each sample edge with a valid addr, pulse chain_shift_ena[addr] with chain_shift_data = mosi, and increment the payload counter.
    - The payload counter saturates at 2^CNT_W-1; shifting continues after saturation.
    - On each launch edge: spi_miso <= chain_shift_out[addr] if addr is valid, else 0.
  - On the synced ss_ rising edge in any non-IDLE state: go to IDLE.
    - From PAYLOAD with a valid addr and payload count >0: pulse chain_update[addr].
    - From PAYLOAD: load xfer_len with the payload count.
    - From ADDR (aborted address): no capture, no update; xfer_len is unchanged.
- spi_miso is 0 in IDLE and ADDR, and returns to 0 on the ss_ rising edge.
- A sample/launch edge coinciding with the ss_ rising edge in the same cycle is ignored; only the end-of-transaction action occurs.
- Edges while ss_ is high are ignored.
- Asynchronous reset mid-transaction aborts immediately: no update pulse. Outputs return to their reset values.
- At most one bit of each strobe vector is high in any cycle. capture, shift_ena and update are never high together.

Decomposition:
- Package icetap_pkg: FSM state enum (IDLE, ADDR, PAYLOAD), and the chain-address constants CHAIN_CMD=0, CHAIN_STATUS=1, CHAIN_DATA=2, CHAIN_STORE_MASK=3, CHAIN_TRIGGER_MASK=4.
- Sub-module icetap_sync_edge: a parametrised SYNC_STAGES synchroniser with reset value and rise/fall detect. Instantiate it three times (clk, ss_, mosi; mosi ignores edge outputs).

Test Plan:
- Mode 0, addr 0x00, payload 0xA5 MSB first -> chain_capture[0] once after the 8th address edge; 8 chain_shift_ena[0] pulses with data 1,0,1,0,0,1,0,1; chain_update[0] once after ss_ rise; xfer_len=8.
- Mode 3 (CPOL=1, CPHA=1), addr 0x02, 16 payload clocks, chain_shift_out[2] driven by a model chain holding 0xBEEF -> MISO sampled by the master reads 0xBEEF; xfer_len=16.
- Addr 0x07 with NUM_CHAINS=5, 8 payload bits -> bad_addr=1; no capture/shift/update pulses; MISO stays 0; xfer_len=8; next valid transaction clears bad_addr.
- ss_ released after 5 address bits -> no strobes; FSM returns to IDLE; xfer_len keeps its previous value.
- Valid addr 0x03 with zero payload bits (ss_ rises right after the address) -> chain_capture[3] pulses; no chain_update; xfer_len=0.
- scan_reset_ asserted after 3 payload bits of addr 0x01 -> all outputs 0 within the reset; no chain_update; the next full transaction behaves normally.
